// File: rtl/calc_pkg.sv
// Shared definitions for the calculator keypad front end: keypad geometry,
// ALU opcode encoding, scanner FSM states and the decoded key classes.
package calc_pkg;

    localparam int ROWS = 6;
    localparam int COLS = 4;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10
    } opcode_e;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_CONFIRM,
        ST_EMIT,
        ST_RELEASE
    } state_e;

    typedef enum logic [2:0] {
        KEY_NONE,
        KEY_HEX,
        KEY_OP,
        KEY_EQ,
        KEY_BS,
        KEY_CE
    } key_class_e;

    // One decoded key: what kind it is plus the payload for hex/operator keys.
    typedef struct packed {
        key_class_e cls;
        logic [3:0] hex;
        opcode_e    op;
    } key_t;

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for asynchronous keypad rows. Resets to all ones,
// which is the idle (no key pressed) level of the pulled-up rows.
module keypad_sync #(
    parameter int WIDTH = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Shift the raw rows through two flops before anyone looks at them.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments let both stages sample their old
        // values on the same edge; blocking would collapse them into one flop.
        if (!rst_ni) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 6x4 matrix keypad scanner with debounce. Drives one column low at a time,
// samples the synchronised rows once per column dwell, debounces press and
// release, and emits exactly one single-cycle event per physical press.
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int CLK_DIV     = 1000,  // clocks per column dwell, >= 3
    parameter int DEB_SAMPLES = 4      // identical samples to accept, >= 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] row_n,
    output logic [3:0] col_n,
    output logic       newhex,
    output logic [3:0] hexcode,
    output logic       newop,
    output logic [1:0] opcode,
    output logic       eq,
    output logic       BS,
    output logic       CE
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int DEB_W = $clog2(DEB_SAMPLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEB_SAMPLES);

    logic [ROWS-1:0]  row_sync;
    logic [ROWS-1:0]  row_low;
    logic             sample;
    logic             one_low;
    logic [2:0]       sample_row;

    state_e           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [1:0]       col_q,     col_d;
    logic [DEB_W-1:0] deb_q,     deb_d;
    logic [2:0]       key_row_q, key_row_d;

    logic             emit_d;
    key_t             key_d;

    logic             newhex_q, newop_q, eq_q, bs_q, ce_q;
    logic [3:0]       hexcode_q;
    opcode_e          opcode_q;

    keypad_sync #(.WIDTH(ROWS)) u_sync (
        .clk_i  (clock),
        .rst_ni (reset),
        .d_i    (row_n),
        .q_o    (row_sync)
    );

    // Map a (row, column) position to the key it represents.
    function automatic key_t decode_key(input logic [2:0] row, input logic [1:0] col);
        key_t k;
        k = '{cls: KEY_NONE, hex: 4'h0, op: OP_ADD};
        if (row < 3'd4) begin
            k.cls = KEY_HEX;
            k.hex = {row[1:0], col};
        end else if (row == 3'd4) begin
            case (col)
                2'd0:    begin k.cls = KEY_OP; k.op = OP_ADD; end
                2'd1:    begin k.cls = KEY_OP; k.op = OP_SUB; end
                2'd2:    begin k.cls = KEY_OP; k.op = OP_MUL; end
                default: k.cls = KEY_EQ;
            endcase
        end else if (row == 3'd5) begin
            case (col)
                2'd0:    k.cls = KEY_BS;
                2'd1:    k.cls = KEY_CE;
                default: k.cls = KEY_NONE;
            endcase
        end
        return k;
    endfunction

    assign row_low = ~row_sync;
    assign sample  = (cnt_q == CNT_LAST);
    // Ghosting (two or more rows low) is treated the same as no key at all.
    assign one_low = (row_low != '0) && ((row_low & (row_low - 6'd1)) == '0);

    // Encode which row is low; only meaningful when exactly one is.
    always_comb begin
        sample_row = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_low[r]) sample_row = 3'(r);
        end
    end

    // Next-state logic for the scan / confirm / emit / release sequence.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        cnt_d     = sample ? '0 : cnt_q + CNT_W'(1);
        col_d     = col_q;
        deb_d     = deb_q;
        key_row_d = key_row_q;

        case (state_q)
            ST_SCAN: begin
                if (sample) begin
                    if (one_low) begin
                        key_row_d = sample_row;
                        deb_d     = DEB_W'(1);
                        state_d   = (DEB_SAMPLES == 1) ? ST_EMIT : ST_CONFIRM;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
            end
            ST_CONFIRM: begin
                if (sample) begin
                    if (one_low && (sample_row == key_row_q)) begin
                        deb_d = deb_q + DEB_W'(1);
                        if (deb_d == DEB_MAX) state_d = ST_EMIT;
                    end else begin
                        state_d = ST_SCAN;
                        col_d   = col_q + 2'd1;
                    end
                end
            end
            ST_EMIT: begin
                state_d = ST_RELEASE;
                deb_d   = '0;
            end
            ST_RELEASE: begin
                if (sample) begin
                    deb_d = (row_low == '0) ? deb_q + DEB_W'(1) : '0;
                    if (deb_d == DEB_MAX) begin
                        state_d = ST_SCAN;
                        col_d   = col_q + 2'd1;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = ST_SCAN;
        endcase
    end

    // The column is frozen while confirming, so col_q is the key's column.
    assign emit_d = (state_d == ST_EMIT);
    assign key_d  = decode_key(key_row_d, col_q);

    // Scanner state registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= ST_SCAN;
            cnt_q     <= '0;
            col_q     <= '0;
            deb_q     <= '0;
            key_row_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            col_q     <= col_d;
            deb_q     <= deb_d;
            key_row_q <= key_row_d;
        end
    end

    // Registered event pulses; they are high exactly during the EMIT cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            newhex_q  <= 1'b0;
            newop_q   <= 1'b0;
            eq_q      <= 1'b0;
            bs_q      <= 1'b0;
            ce_q      <= 1'b0;
            hexcode_q <= '0;
            opcode_q  <= OP_ADD;
        end else begin
            newhex_q <= emit_d && (key_d.cls == KEY_HEX);
            newop_q  <= emit_d && (key_d.cls == KEY_OP);
            eq_q     <= emit_d && (key_d.cls == KEY_EQ);
            bs_q     <= emit_d && (key_d.cls == KEY_BS);
            ce_q     <= emit_d && (key_d.cls == KEY_CE);
            if (emit_d && (key_d.cls == KEY_HEX)) hexcode_q <= key_d.hex;
            if (emit_d && (key_d.cls == KEY_OP))  opcode_q  <= key_d.op;
        end
    end

    assign col_n   = ~(4'b0001 << col_q);
    assign newhex  = newhex_q;
    assign hexcode = hexcode_q;
    assign newop   = newop_q;
    assign opcode  = opcode_q;
    assign eq      = eq_q;
    assign BS      = bs_q;
    assign CE      = ce_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner (CLK_DIV=4, DEB_SAMPLES=3).
// A physical keypad model turns the pressed-key matrix into row levels, and a
// behavioural reference predicts every output cycle by cycle.
module tb_keypad_scanner;

    localparam int CLK_DIV = 4;
    localparam int DEB     = 3;

    localparam int M_SCAN    = 0;
    localparam int M_CONFIRM = 1;
    localparam int M_EMIT    = 2;
    localparam int M_RELEASE = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] row_n = '1;
    logic [3:0] col_n;
    logic       newhex, newop, eq, BS, CE;
    logic [3:0] hexcode;
    logic [1:0] opcode;

    keypad_scanner #(.CLK_DIV(CLK_DIV), .DEB_SAMPLES(DEB)) dut (
        .clock   (clock),
        .reset   (reset),
        .row_n   (row_n),
        .col_n   (col_n),
        .newhex  (newhex),
        .hexcode (hexcode),
        .newop   (newop),
        .opcode  (opcode),
        .eq      (eq),
        .BS      (BS),
        .CE      (CE)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Keypad: a pressed key pulls its row low while its column is driven low.
    bit pressed [6][4];

    function automatic logic [5:0] rows_from_coln(input logic [3:0] cn);
        logic [5:0] rows;
        rows = '1;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r][c] && !cn[c]) rows[r] = 1'b0;
        return rows;
    endfunction

    task automatic clear_keys();
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 4; c++)
                pressed[r][c] = 1'b0;
    endtask

    // Reference model state.
    logic [5:0] m_sync1, m_sync2;
    int         m_cnt, m_col, m_phase, m_key_r, m_deb;
    logic [4:0] exp_pulse;   // {newhex, newop, eq, BS, CE}
    logic [3:0] exp_hex;
    logic [1:0] exp_op;

    task automatic model_emit();
        m_phase = M_EMIT;
        if (m_key_r < 4) begin
            exp_pulse[4] = 1'b1;
            exp_hex      = 4'(4 * m_key_r + m_col);
        end else if (m_key_r == 4) begin
            if (m_col < 3) begin
                exp_pulse[3] = 1'b1;
                exp_op       = 2'(m_col);
            end else begin
                exp_pulse[2] = 1'b1;
            end
        end else begin
            if (m_col == 0)      exp_pulse[1] = 1'b1;
            else if (m_col == 1) exp_pulse[0] = 1'b1;
        end
    endtask

    task automatic model_step(input bit in_reset, input logic [5:0] rows_in);
        logic [5:0] seen;
        int         nlow;
        int         low_row;
        bit         at_sample;
        if (in_reset) begin
            m_sync1 = '1; m_sync2 = '1;
            m_cnt = 0; m_col = 0; m_phase = M_SCAN; m_key_r = 0; m_deb = 0;
            exp_pulse = '0; exp_hex = '0; exp_op = '0;
            return;
        end
        seen      = m_sync2;
        at_sample = (m_cnt == CLK_DIV - 1);
        m_sync2   = m_sync1;
        m_sync1   = rows_in;
        m_cnt     = (m_cnt + 1) % CLK_DIV;
        exp_pulse = '0;
        nlow      = $countones(~seen);
        low_row   = 0;
        for (int r = 0; r < 6; r++) if (!seen[r]) low_row = r;

        if (m_phase == M_EMIT) begin
            m_phase = M_RELEASE;
            m_deb   = 0;
        end else if (at_sample) begin
            case (m_phase)
                M_SCAN: begin
                    if (nlow == 1) begin
                        m_key_r = low_row;
                        m_deb   = 1;
                        if (DEB == 1) model_emit();
                        else          m_phase = M_CONFIRM;
                    end else begin
                        m_col = (m_col + 1) % 4;
                    end
                end
                M_CONFIRM: begin
                    if (nlow == 1 && low_row == m_key_r) begin
                        m_deb++;
                        if (m_deb == DEB) model_emit();
                    end else begin
                        m_phase = M_SCAN;
                        m_col   = (m_col + 1) % 4;
                    end
                end
                default: begin
                    if (nlow == 0) m_deb++;
                    else           m_deb = 0;
                    if (m_deb == DEB) begin
                        m_phase = M_SCAN;
                        m_col   = (m_col + 1) % 4;
                        m_cnt   = 0;
                    end
                end
            endcase
        end
    endtask

    // Events observed on the DUT since the last clear_log().
    int         cyc;
    int         ev_hex, ev_op, ev_eq, ev_bs, ev_ce, first_hex;
    logic [3:0] last_hex;
    logic [1:0] last_op;

    task automatic clear_log();
        ev_hex = 0; ev_op = 0; ev_eq = 0; ev_bs = 0; ev_ce = 0;
        first_hex = -1; last_hex = '0; last_op = '0;
    endtask

    function automatic int total_events();
        return ev_hex + ev_op + ev_eq + ev_bs + ev_ce;
    endfunction

    // One clock: settle rows, advance the model, then compare after the edge.
    task automatic tick();
        bit         rst_at_edge;
        logic [3:0] model_cn;
        logic [4:0] pulses;
        #1;
        row_n       = rows_from_coln(col_n);
        rst_at_edge = (reset == 1'b0);
        model_cn    = ~(4'b0001 << m_col);
        model_step(rst_at_edge, rows_from_coln(model_cn));
        @(posedge clock);
        @(negedge clock);
        if (!rst_at_edge) cyc++;
        model_cn = ~(4'b0001 << m_col);
        pulses   = {newhex, newop, eq, BS, CE};
        check("col_n",   32'(col_n),   32'(model_cn));
        check("pulses",  32'(pulses),  32'(exp_pulse));
        check("hexcode", 32'(hexcode), 32'(exp_hex));
        check("opcode",  32'(opcode),  32'(exp_op));
        check("one_hot", 32'($countones(pulses) <= 1), 32'(1));
        if (newhex) begin
            ev_hex++;
            last_hex = hexcode;
            if (first_hex < 0) first_hex = cyc;
        end
        if (newop) begin ev_op++; last_op = opcode; end
        if (eq) ev_eq++;
        if (BS) ev_bs++;
        if (CE) ev_ce++;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic run_until_phase(input string tag, input int ph, input int max_cycles);
        int n;
        n = 0;
        while (m_phase != ph && n < max_cycles) begin
            tick();
            n++;
        end
        check(tag, 32'(n < max_cycles), 32'(1));
    endtask

    // Two reset cycles, direct reset-value checks, then release (cycle 0).
    task automatic apply_reset();
        reset = 1'b0;
        run(2);
        check("rst_col_n",   32'(col_n), 32'(4'b1110));
        check("rst_pulses",  32'({newhex, newop, eq, BS, CE}), 32'(0));
        check("rst_hexcode", 32'(hexcode), 32'(0));
        check("rst_opcode",  32'(opcode), 32'(0));
        reset = 1'b1;
        cyc   = 0;
        clear_log();
    endtask

    typedef struct packed {
        logic [2:0] r;
        logic [1:0] c;
        logic [4:0] pv;
        logic [1:0] op;
    } sweep_t;

    sweep_t sw [8];

    initial begin
        logic [3:0] exp_cn;
        int         r0, c0, hold, gap;

        sw[0] = '{3'd4, 2'd0, 5'b01000, 2'b00};
        sw[1] = '{3'd4, 2'd1, 5'b01000, 2'b01};
        sw[2] = '{3'd4, 2'd2, 5'b01000, 2'b10};
        sw[3] = '{3'd4, 2'd3, 5'b00100, 2'b00};
        sw[4] = '{3'd5, 2'd0, 5'b00010, 2'b00};
        sw[5] = '{3'd5, 2'd1, 5'b00001, 2'b00};
        sw[6] = '{3'd5, 2'd2, 5'b00000, 2'b00};
        sw[7] = '{3'd5, 2'd3, 5'b00000, 2'b00};

        clear_keys();
        clear_log();
        cyc = 0;

        // Idle scanning: each column held for four cycles, no events.
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            tick();
            exp_cn = ~(4'b0001 << ((cyc / 4) % 4));
            check("idle_col_n", 32'(col_n), 32'(exp_cn));
        end
        check("idle_events", 32'(total_events()), 32'(0));

        // Column-0 key held through reset: pulse lands in cycle 12.
        clear_keys();
        pressed[1][0] = 1'b1;
        apply_reset();
        run(40);
        check("lat_count",   32'(ev_hex),    32'(1));
        check("lat_cycle",   32'(first_hex), 32'(12));
        check("lat_hexcode", 32'(last_hex),  32'(4));
        clear_keys();
        run(30);

        // '7' held from reset: one event only, then scanning resumes.
        pressed[1][3] = 1'b1;
        apply_reset();
        run(80);
        check("k7_count",   32'(total_events()), 32'(1));
        check("k7_hexcode", 32'(last_hex),       32'(7));
        clear_keys();
        run(40);
        check("k7_after_release", 32'(total_events()), 32'(1));

        // Bounce: first sample low, second high, then stable low.
        clear_keys();
        pressed[2][0] = 1'b1;
        apply_reset();
        run_until_phase("bounce_wait_confirm", M_CONFIRM, 50);
        pressed[2][0] = 1'b0;
        run_until_phase("bounce_wait_scan", M_SCAN, 50);
        check("bounce_no_early", 32'(total_events()), 32'(0));
        pressed[2][0] = 1'b1;
        run(80);
        check("bounce_count",   32'(ev_hex),         32'(1));
        check("bounce_total",   32'(total_events()), 32'(1));
        check("bounce_hexcode", 32'(last_hex),       32'(8));
        clear_keys();
        run(30);

        // Ghost: two rows low in one column is ignored, columns keep cycling.
        pressed[0][2] = 1'b1;
        pressed[1][2] = 1'b1;
        apply_reset();
        for (int i = 0; i < 48; i++) begin
            tick();
            exp_cn = ~(4'b0001 << ((cyc / 4) % 4));
            check("ghost_col_n", 32'(col_n), 32'(exp_cn));
        end
        check("ghost_events", 32'(total_events()), 32'(0));
        clear_keys();

        // Decode sweep over the operator / control row keys.
        for (int i = 0; i < 8; i++) begin
            clear_keys();
            pressed[int'(sw[i].r)][int'(sw[i].c)] = 1'b1;
            apply_reset();
            run(40);
            clear_keys();
            run(30);
            check("sweep_newhex", 32'(ev_hex), 32'(sw[i].pv[4]));
            check("sweep_newop",  32'(ev_op),  32'(sw[i].pv[3]));
            check("sweep_eq",     32'(ev_eq),  32'(sw[i].pv[2]));
            check("sweep_bs",     32'(ev_bs),  32'(sw[i].pv[1]));
            check("sweep_ce",     32'(ev_ce),  32'(sw[i].pv[0]));
            check("sweep_total",  32'(total_events()), 32'($countones(sw[i].pv)));
            if (sw[i].pv[3]) check("sweep_opcode", 32'(last_op), 32'(sw[i].op));
        end

        // Reset pulse during CONFIRM of r0c1 aborts it; fresh debounce after.
        clear_keys();
        pressed[0][1] = 1'b1;
        apply_reset();
        run_until_phase("rstmid_wait_confirm", M_CONFIRM, 50);
        reset = 1'b0;
        tick();
        check("rstmid_col_n",  32'(col_n), 32'(4'b1110));
        check("rstmid_pulses", 32'({newhex, newop, eq, BS, CE}), 32'(0));
        reset = 1'b1;
        cyc   = 0;
        clear_log();
        run(40);
        check("rstmid_count",   32'(ev_hex),    32'(1));
        check("rstmid_cycle",   32'(first_hex), 32'(16));
        check("rstmid_hexcode", 32'(last_hex),  32'(1));
        clear_keys();
        run(30);

        // Random presses with chatter, occasional second key and resets.
        for (int it = 0; it < 40; it++) begin
            clear_keys();
            r0 = int'($urandom_range(0, 5));
            c0 = int'($urandom_range(0, 3));
            pressed[r0][c0] = 1'b1;
            if ($urandom_range(0, 3) == 0)
                pressed[$urandom_range(0, 5)][$urandom_range(0, 3)] = 1'b1;
            hold = int'($urandom_range(5, 90));
            for (int k = 0; k < hold; k++) begin
                if ($urandom_range(0, 7) == 0) pressed[r0][c0] = ~pressed[r0][c0];
                tick();
            end
            clear_keys();
            gap = int'($urandom_range(5, 60));
            run(gap);
            if ($urandom_range(0, 9) == 0) apply_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
